// File: rtl/elastic_stage_reg_pkg.sv
// Shared pipeline flow types: per-flow NOP payloads
// and the elastic stage register occupancy state.
package pipeline_flow_types;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] NOP_EX_MEM_FLOW = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } elastic_state_t;

endpackage

// File: rtl/elastic_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear;
// clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/elastic_stage_reg.sv
// Valid/ready elastic stage register with optional
// two-entry skid buffer, flush and stall counter.
module elastic_stage_reg
  import pipeline_flow_types::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               SKID      = 1,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  elastic_state_t   state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             emit;

  assign out_valid = (state_q != EMPTY);
  // The mux guarantees no stale payload leaks out.
  assign out_data  = out_valid ? main_q : NOP_VALUE;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != TWO);
    end else begin : g_pass
      assign in_ready = (state_q == EMPTY) || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid && !out_ready),
    .clr  (stall_clr),
    .cnt  (stall_cnt)
  );

endmodule

// File: doc/elastic_stage_reg.md
# elastic_stage_reg

Parametrised successor to the fixed inter-stage pipeline registers: a valid/ready elastic stage register carrying an opaque WIDTH-bit flow struct between any two pipeline stages. It adds back-pressure, an optional two-entry skid buffer for full throughput with a registered ready, a synchronous flush that inserts a NOP bubble, and a saturating stall-cycle counter for performance debug.

## Interface
- WIDTH, 32: payload width in bits; the packed flow struct of the stage pair.
- NOP_VALUE, '0: payload driven on out_data whenever out_valid=0, and the reset value.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: stall counter width, minimum 1.

Ports:
- clk  input  1  clock. Reset is asynchronous, active-high; clock is clk.
- reset  input  1  asynchronous active-high reset.
- flush  input  1  synchronous; discards all held entries.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage accepts this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is a real payload.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  WIDTH  payload, or NOP_VALUE when out_valid=0.
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- stall_clr  input  1  synchronous clear of stall_cnt.

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Entries: main holds out_data/out_valid; skid (SKID=1 only) holds one overflow payload.
- SKID=1 state machine (EMPTY, ONE, TWO); in_ready = (state != TWO), a pure function of registered state.
  - EMPTY: accept -> ONE, main <= in_data.
  - ONE: accept && !emit -> TWO, skid <= in_data. Accept && emit -> ONE, main <= in_data. Emit only -> EMPTY. Neither -> ONE.
  - TWO: emit -> ONE, main <= skid. No accept is possible.
- SKID=0: in_ready = !out_valid || out_ready (combinational). Accept loads main; emit without accept clears out_valid.
- Flush has priority over accept and emit. Next state is EMPTY, out_valid <= 0 and out_data <= NOP_VALUE. A payload presented in the flush cycle is dropped even if in_ready=1.
- Whenever out_valid=0, out_data must equal NOP_VALUE; stale payloads are never exposed.
- Ordering is strictly FIFO. No payload is duplicated or lost except by flush.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready and saturates at 2^CNT_W-1. stall_clr has priority over increment. Flush does not clear stall_cnt.

## Timing
- Reset values: out_valid=0, out_data=NOP_VALUE, stall_cnt=0, state=EMPTY, in_ready=1 in both modes.
- Latency is exactly 1 cycle from accept to out_valid when the stage is empty.
- Throughput is 1 payload per cycle with out_ready held at 1, in both modes.
- Under back-pressure with SKID=1, in_ready falls on the cycle after the second accept.
- When out_ready rises in TWO, the skid payload appears on out_data the following cycle, and in_ready=1 in that same cycle.
- Reset asserted mid-operation returns every output to its reset value immediately and asynchronously. The first accept is possible on the first clk edge after deassertion.
- Simultaneous flush and stall_clr: both take effect.

## Structure
- NOP constants per flow type (e.g. NOP_EX_MEM_FLOW) stay in the shared pipeline_flow_types package and are passed as NOP_VALUE. Add the state enum elastic_state_t {EMPTY, ONE, TWO} to that package.
- One natural sub-module: sat_counter (parameters CNT_W; inputs inc, clr), also reusable for other performance counters.
- Each existing fixed stage register is an instance with WIDTH=$bits(flow_t), with out_ready tied high for legacy behaviour.

## Test plan
- Reset with in_valid=1 and in_data=0xA5 held through reset -> out_valid=0, out_data=NOP_VALUE=0x13, in_ready=1. After deassertion, 0xA5 appears on the next cycle.
- Streaming 0x01..0x08 with out_ready=1, SKID=1 -> one payload per cycle, 1-cycle latency, stall_cnt=0.
- SKID=1: accept 0x11 and 0x22 with out_ready=0 -> in_ready=0 from the cycle after 0x22's accept, stall_cnt counts. Raise out_ready -> 0x11 then 0x22, no loss, in_ready returns to 1.
- Flush in state TWO while in_valid=1 with 0x33 -> next cycle out_valid=0, out_data=NOP_VALUE, 0x33 never emitted, in_ready=1.
- CNT_W=3, out_ready=0 for 10 cycles -> stall_cnt saturates at 7. Then stall_clr together with a stall cycle -> 0.
- SKID=0, out_ready toggling 1,0,1 with continuous input -> in_ready tracks !out_valid||out_ready in the same cycle, and the output sequence matches the input order.
